fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer/flow-control front end for the dual-port Memory block; together they form a synchronous FIFO.
- Accepts words from an upstream valid/ready stream and writes them into Memory.
- Prefetches words from Memory into a 2-entry output stage, which presents a first-word-fall-through valid/ready stream downstream.
- Handles Memory's read latency for both SHOWAHEAD settings; the top level instantiates and wires the controller and Memory side by side.

Parameters:
- MEM_WIDTH_BYTES, 4, word width in bytes; must match Memory.
- MEM_DEPTH, 16, Memory entries; power of two, ≥2.
- SHOWAHEAD, 0, must match Memory. 0: read data valid one cycle after the read address. 1: read data valid in the same cycle.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  controller can accept a word
- in_data  in  MEM_WIDTH_BYTES*8  upstream word
- out_valid  out  1  output-stage head valid
- out_ready  in  1  downstream accepts the head
- out_data  out  MEM_WIDTH_BYTES*8  output-stage head word
- mem_write_addr_out  out  $clog2(MEM_DEPTH)  to Memory write_addr_in
- mem_write_out  out  1  to Memory write_in
- mem_data_out  out  MEM_WIDTH_BYTES*8  to Memory data_in
- mem_read_addr_out  out  $clog2(MEM_DEPTH)  to Memory read_addr_in
- mem_read_out  out  1  to Memory read_in
- mem_data_in  in  MEM_WIDTH_BYTES*8  from Memory data_out
- count_out  out  $clog2(MEM_DEPTH+2)+1  words held (memory + in flight + output stage)
- empty_out  out  1  count_out==0
- full_out  out  1  mem_count==MEM_DEPTH
- debugen_in  in  1  enable $write trace

Behaviour:
- State registers: wr_ptr, rd_ptr (wrap modulo MEM_DEPTH), mem_count (0..MEM_DEPTH), rd_pending (SHOWAHEAD=0 only), ob[2] with ob_count (0..2).
- Reset (reset low, asynchronous): all state cleared; out_valid=0, empty_out=1, full_out=0, count_out=0, in_ready=0 while reset is low; mem_write_out=0, mem_read_out=0.
- After release, in_ready = (mem_count < MEM_DEPTH).
- Push = in_valid && in_ready.
  - mem_write_out=push, mem_write_addr_out=wr_ptr, mem_data_out=in_data (combinational).
  - On push: wr_ptr+1, mem_count+1.
- Pop = out_valid && out_ready; out_valid = (ob_count>0); out_data = ob[0].
  - On pop: ob shifts by one.
- Read issue:
  - issue = (mem_count>0) && (ob_count + rd_pending − pop < 2).
  - mem_read_out=issue, mem_read_addr_out=rd_ptr.
  - On issue: rd_ptr+1, mem_count−1.
  - A simultaneous push and issue leaves mem_count unchanged.
- Read data capture:
  - SHOWAHEAD=0: rd_pending <= issue; when rd_pending=1, mem_data_in is appended to ob this edge.
  - SHOWAHEAD=1: mem_data_in is appended on the issue edge.
  - The append lands after any pop shift in the same edge.
- Latency:
  - SHOWAHEAD=0: push accepted at edge E0 → out_valid after E2.
  - SHOWAHEAD=1: push accepted at edge E0 → out_valid after E1.
  - Steady state: one word per cycle both ways with no bubbles.
- Hazards:
  - Reads only target entries counted in registered mem_count, so a same-address read/write in the same cycle never occurs.
  - Total capacity = MEM_DEPTH+2.
- count_out = mem_count + rd_pending + ob_count (registered terms only). full_out is derived from mem_count; empty_out from count_out.
- Wrap: pointers roll from MEM_DEPTH−1 to 0; ordering is preserved across wrap.
- Reset mid-operation: all contents are discarded and the in-flight read is dropped; Memory contents are irrelevant.
- debugen_in=1: $write("%m: push %x@%x / pop %x\n") on each push and pop edge.

Decomposition:
- Shared package:
  - typedef for the word type (logic[MEM_WIDTH_BYTES*8-1:0]);
  - typedef for the pointer type;
  - function fifo_count_width(depth) returning $clog2(depth+2)+1.
- Sub-module fifo_out_stage: 2-entry skid/output buffer with push/pop/count.
- Pointers, mem_count and issue logic stay in fifo_ctrl.

Test Plan:
- Reset: hold reset low 3 cycles, release → in_ready=1, out_valid=0, count_out=0, empty_out=1, mem_read_out=0.
- Streaming (SHOWAHEAD=0): in_valid=1 with data 0,1,2,… and out_ready=1 → first out_valid two edges after first push; then out_data increments every cycle; count_out ≤3.
- Fill (MEM_DEPTH=16): out_ready=0, push continuously → exactly 18 words accepted; full_out=1, in_ready=0, count_out=18. Then out_ready=1 → 18 words out in order, then empty_out=1.
- Wrap: 40 words with random in_valid/out_ready (50%) → order and values preserved, no loss or duplication; wr_ptr wraps twice.
- SHOWAHEAD=1: single push of 0xA5A5A5A5 → out_valid after one edge with out_data=0xA5A5A5A5.
- Mid-operation reset: 10 words queued, reset pulsed low for 1 cycle asynchronously → outputs cleared immediately. After release, next pushed word 0x55 is the first word popped.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and sizing helpers for the FIFO controller and its output stage.
package fifo_ctrl_pkg;

    localparam int DEF_WIDTH_BYTES = 4;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_SHOWAHEAD   = 0;

    typedef logic [DEF_WIDTH_BYTES*8-1:0] word_t;
    typedef logic [$clog2(DEF_DEPTH)-1:0] ptr_t;

    // Occupancy counter width: memory + one read in flight + two output slots.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 2) + 1;
    endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// Two-entry first-word-fall-through output buffer; appends land after a same-edge pop.
module fifo_out_stage
    import fifo_ctrl_pkg::*;
#(
    parameter int W = DEF_WIDTH_BYTES * 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] ob_q [2];
    logic [W-1:0] ob_d [2];
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         pop_eff;

    assign pop_eff = pop_i && (count_q != 2'd0);

    // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        ob_d    = ob_q;
        count_d = count_q;
        if (pop_eff) begin
            ob_d[0] = ob_q[1];
            count_d = count_q - 2'd1;
        end
        if (push_i) begin
            if (count_d == 2'd0) begin
                ob_d[0] = push_data_i;
            end else begin
                ob_d[1] = push_data_i;
            end
            count_d = count_d + 2'd1;
        end
    end

    // NOTE: the two data slots are reset as well; they are tiny and it keeps out_data deterministic.
    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_q[0] <= '0;
            ob_q[1] <= '0;
            count_q <= 2'd0;
        end else begin
            ob_q[0] <= ob_d[0];
            ob_q[1] <= ob_d[1];
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = ob_q[0];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flow-control front end for a dual-port memory, forming a synchronous
// FIFO with a valid/ready input and a first-word-fall-through valid/ready output.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH_BYTES = DEF_WIDTH_BYTES,
    parameter int MEM_DEPTH       = DEF_DEPTH,
    parameter int SHOWAHEAD       = DEF_SHOWAHEAD
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [MEM_WIDTH_BYTES*8-1:0]           in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [MEM_WIDTH_BYTES*8-1:0]           out_data,
    output logic [$clog2(MEM_DEPTH)-1:0]           mem_write_addr_out,
    output logic                                   mem_write_out,
    output logic [MEM_WIDTH_BYTES*8-1:0]           mem_data_out,
    output logic [$clog2(MEM_DEPTH)-1:0]           mem_read_addr_out,
    output logic                                   mem_read_out,
    input  logic [MEM_WIDTH_BYTES*8-1:0]           mem_data_in,
    output logic [fifo_count_width(MEM_DEPTH)-1:0] count_out,
    output logic                                   empty_out,
    output logic                                   full_out,
    input  logic                                   debugen_in
);

    localparam int W   = MEM_WIDTH_BYTES * 8;
    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int CW  = fifo_count_width(MEM_DEPTH);
    localparam int MCW = $clog2(MEM_DEPTH + 1);
    localparam logic [MCW-1:0] MEM_FULL = MCW'(MEM_DEPTH);

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [MCW-1:0] mem_count_q, mem_count_d;
    logic           rd_pending_q, rd_pending_d;

    logic           push;
    logic           pop;
    logic           issue;
    logic           ob_push;
    logic [1:0]     ob_count;
    logic [2:0]     ob_demand;

    assign in_ready = reset && (mem_count_q != MEM_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Slots the output stage will have claimed after this edge; keep a read only if one is free.
    assign ob_demand = {1'b0, ob_count} + {2'b0, rd_pending_q} - {2'b0, pop};
    assign issue     = (mem_count_q != '0) && (ob_demand < 3'd2);

    assign mem_write_out      = push;
    assign mem_write_addr_out = wr_ptr_q;
    assign mem_data_out       = in_data;
    assign mem_read_out       = issue;
    assign mem_read_addr_out  = rd_ptr_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_count_d  = mem_count_q;
        rd_pending_d = (SHOWAHEAD == 0) ? issue : 1'b0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, issue})
            2'b10:   mem_count_d = mem_count_q + 1'b1;
            2'b01:   mem_count_d = mem_count_q - 1'b1;
            default: mem_count_d = mem_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_count_q  <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_count_q  <= mem_count_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    // Show-ahead memory returns data with the address; otherwise it arrives a cycle later.
    assign ob_push = (SHOWAHEAD != 0) ? issue : rd_pending_q;

    fifo_out_stage #(
        .W (W)
    ) u_out_stage (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (ob_push),
        .push_data_i (mem_data_in),
        .pop_i       (pop),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .count_o     (ob_count)
    );

    assign count_out = CW'(mem_count_q) + CW'(rd_pending_q) + CW'(ob_count);
    assign empty_out = (count_out == '0);
    assign full_out  = (mem_count_q == MEM_FULL);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && debugen_in && (push || pop)) begin
            $write("%m: push %x@%x / pop %x\n", in_data, wr_ptr_q, out_data);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a queue-based FIFO model checked every cycle, plus directed
// latency, fill, wrap, show-ahead and mid-operation reset scenarios.
module tb_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int W     = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 2) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // SHOWAHEAD = 0 instance
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [AW-1:0] m_waddr, m_raddr;
    logic          m_we, m_re;
    logic [W-1:0]  m_wdata, m_rdata;
    logic [CW-1:0] count_out;
    logic          empty_out, full_out;

    // SHOWAHEAD = 1 instance
    logic          in_valid1, in_ready1, out_valid1, out_ready1;
    logic [W-1:0]  in_data1, out_data1;
    logic [AW-1:0] m_waddr1, m_raddr1;
    logic          m_we1, m_re1;
    logic [W-1:0]  m_wdata1, m_rdata1;
    logic [CW-1:0] count_out1;
    logic          empty_out1, full_out1;

    logic debugen = 1'b0;

    fifo_ctrl #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(DEPTH), .SHOWAHEAD(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_write_addr_out(m_waddr), .mem_write_out(m_we), .mem_data_out(m_wdata),
        .mem_read_addr_out(m_raddr), .mem_read_out(m_re), .mem_data_in(m_rdata),
        .count_out(count_out), .empty_out(empty_out), .full_out(full_out),
        .debugen_in(debugen)
    );

    fifo_ctrl #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(DEPTH), .SHOWAHEAD(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .mem_write_addr_out(m_waddr1), .mem_write_out(m_we1), .mem_data_out(m_wdata1),
        .mem_read_addr_out(m_raddr1), .mem_read_out(m_re1), .mem_data_in(m_rdata1),
        .count_out(count_out1), .empty_out(empty_out1), .full_out(full_out1),
        .debugen_in(debugen)
    );

    // Memory models: registered read for instance 0, show-ahead read for instance 1.
    logic [W-1:0] mem0 [DEPTH];
    logic [W-1:0] mem1 [DEPTH];
    always @(posedge clk) begin
        if (m_we) mem0[m_waddr] <= m_wdata;
        if (m_re) m_rdata <= mem0[m_raddr];
        if (m_we1) mem1[m_waddr1] <= m_wdata1;
    end
    assign m_rdata1 = mem1[m_raddr1];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: ordered list of every word the FIFO currently holds.
    logic [W-1:0] model_q [$];
    bit chk_en = 1'b0;
    int acc_cnt = 0;
    int pop_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            model_q.delete();
        end else if (chk_en) begin
            check("m_count", 64'(count_out), 64'(model_q.size()));
            check("m_empty", 64'(empty_out), 64'(model_q.size() == 0));
            check("m_ready_vs_full", 64'(in_ready), 64'(!full_out));
            check("m_wr_strobe", 64'(m_we), 64'(in_valid && in_ready));
            if (model_q.size() == 0) check("m_valid_when_empty", 64'(out_valid), 64'd0);
            if (model_q.size() < DEPTH) check("m_ready_room", 64'(in_ready), 64'd1);
            if (model_q.size() == DEPTH + 2) check("m_ready_full", 64'(in_ready), 64'd0);
            if (out_valid && model_q.size() > 0) check("m_head_data", 64'(out_data), 64'(model_q[0]));
            if (in_valid && in_ready) begin
                model_q.push_back(in_data);
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                if (model_q.size() > 0) void'(model_q.pop_front());
                pop_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!empty_out && n < 200) begin
            step();
            n++;
        end
        check(name, 64'(empty_out), 64'd1);
    endtask

    initial begin
        int bubbles, maxc, a0, p0, k, n;
        bit acc;

        reset = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

        // Reset held three cycles, released away from the edge
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count_out), 64'd0);
        check("rst_empty", 64'(empty_out), 64'd1);
        check("rst_full", 64'(full_out), 64'd0);
        check("rst_mem_read", 64'(m_re), 64'd0);
        chk_en = 1'b1;
        step();

        // Show-ahead instance: visible one edge after the push
        in_valid1 = 1'b1; in_data1 = 32'hA5A5_A5A5;
        step();
        in_valid1 = 1'b0;
        check("sa1_after_e0", 64'(out_valid1), 64'd0);
        step();
        check("sa1_after_e1_valid", 64'(out_valid1), 64'd1);
        check("sa1_after_e1_data", 64'(out_data1), 64'hA5A5_A5A5);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("sa1_drained", 64'(empty_out1), 64'd1);

        // Single-word latency with registered-read memory: visible after E2
        in_valid = 1'b1; in_data = 32'h0000_0100;
        step();
        in_valid = 1'b0;
        check("lat_after_e0", 64'(out_valid), 64'd0);
        step();
        check("lat_after_e1", 64'(out_valid), 64'd0);
        step();
        check("lat_after_e2_valid", 64'(out_valid), 64'd1);
        check("lat_after_e2_data", 64'(out_data), 64'h100);
        wait_empty("lat_empty");

        // Streaming both ways: no bubbles once primed, occupancy stays small
        p0 = pop_cnt; bubbles = 0; maxc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = 32'h1000 + i;
            step();
            if (i == 1) check("stream_first_e1", 64'(out_valid), 64'd0);
            if (i >= 2 && !out_valid) bubbles++;
            if (int'(count_out) > maxc) maxc = int'(count_out);
        end
        in_valid = 1'b0;
        check("stream_bubbles", 64'(bubbles), 64'd0);
        check("stream_max_count_le3", 64'(maxc <= 3), 64'd1);
        wait_empty("stream_empty");
        check("stream_pops", 64'(pop_cnt - p0), 64'd30);

        // Fill with the sink stalled: memory plus both output slots
        a0 = acc_cnt;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            in_data = 32'h200 + i;
            step();
        end
        in_valid = 1'b0;
        check("fill_accepted", 64'(acc_cnt - a0), 64'd18);
        check("fill_full", 64'(full_out), 64'd1);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_count", 64'(count_out), 64'd18);
        check("fill_head", 64'(out_data), 64'h200);
        p0 = pop_cnt;
        wait_empty("fill_empty");
        check("fill_pops", 64'(pop_cnt - p0), 64'd18);

        // Random throttling on both sides across pointer wrap
        p0 = pop_cnt; k = 0; n = 0;
        while (k < 40 && n < 2000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 32'h300 + k;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) k++;
            n++;
        end
        in_valid = 1'b0;
        check("wrap_words_pushed", 64'(k), 64'd40);
        wait_empty("wrap_empty");
        check("wrap_pops", 64'(pop_cnt - p0), 64'd40);

        // Mid-operation asynchronous reset discards everything
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h400 + i;
            step();
        end
        in_valid = 1'b0;
        check("mid_count_before", 64'(count_out), 64'd10);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(count_out), 64'd0);
        check("mid_rst_empty", 64'(empty_out), 64'd1);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_full", 64'(full_out), 64'd0);
        check("mid_rst_mem_wr", 64'(m_we), 64'd0);
        check("mid_rst_mem_rd", 64'(m_re), 64'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        step();
        in_valid = 1'b1; in_data = 32'h55;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check("mid_post_valid", 64'(out_valid), 64'd1);
        check("mid_post_data", 64'(out_data), 64'h55);
        wait_empty("mid_post_empty");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
